// File: rtl/bus_protocol_master_if.sv
// Signal bundle between the byte bus master, its upstream valid/ready source and the bus target.
// The master modport is the view taken by bus_protocol_master.
interface bus_protocol_master_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       dValid;
  logic [7:0] data;
  logic       dAck;
  logic       xfer_done;
  logic       xfer_drop;
  logic       ack_early;

  modport master (
    input  in_valid,
    input  in_data,
    input  dAck,
    output in_ready,
    output dValid,
    output data,
    output xfer_done,
    output xfer_drop,
    output ack_early
  );

  modport slave (
    output in_valid,
    output in_data,
    output dAck,
    input  in_ready,
    input  dValid,
    input  data,
    input  xfer_done,
    input  xfer_drop,
    input  ack_early
  );
endinterface

// File: rtl/bus_protocol_master.sv
// Initiator for the dValid/dAck byte bus: buffers upstream bytes in a FIFO and presents each one
// as a 2..4 clock dValid burst, retrying on timeout up to MAX_RETRY times before dropping it.
module bus_protocol_master #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_RETRY = 2
) (
  input logic                          clk,
  input logic                          reset,
  bus_protocol_master_if.master        bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] MaxRetry = RW'(MAX_RETRY);

  typedef enum logic [1:0] {
    StIdle,
    StValid,
    StGap
  } state_e;

  // FIFO storage; pointers carry one extra wrap bit to tell full from empty
  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        full, empty, push, pop;
  logic [7:0]  head;

  state_e      state_q, state_d;
  logic [2:0]  vcnt_q, vcnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic        dack_q;
  logic        dvalid_q, dvalid_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;
  logic        drop_q, drop_d;
  logic        early_q, early_d;
  logic        ack_qual;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign push  = bus.in_valid && !full;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  assign bus.in_ready  = !full;
  assign bus.dValid    = dvalid_q;
  assign bus.data      = data_q;
  assign bus.xfer_done = done_q;
  assign bus.xfer_drop = drop_q;
  assign bus.ack_early = early_q;

  // Only a fresh rise of dAck from burst clock 2 onward counts as an acknowledge
  assign ack_qual = bus.dAck && !dack_q && (vcnt_q >= 3'd2);

  always_comb begin
    state_d  = state_q;
    vcnt_d   = vcnt_q;
    rcnt_d   = rcnt_q;
    dvalid_d = dvalid_q;
    data_d   = data_q;
    pop      = 1'b0;
    done_d   = 1'b0;
    drop_d   = 1'b0;
    early_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          data_d   = head;
          dvalid_d = 1'b1;
          vcnt_d   = 3'd1;
          state_d  = StValid;
        end
      end
      StValid: begin
        if (ack_qual) begin
          dvalid_d = 1'b0;
          pop      = 1'b1;
          done_d   = 1'b1;
          rcnt_d   = '0;
          state_d  = StGap;
        end else begin
          if (bus.dAck && (vcnt_q == 3'd1)) begin
            early_d = 1'b1;
          end
          if (vcnt_q < 3'd4) begin
            vcnt_d = vcnt_q + 3'd1;
          end else begin
            dvalid_d = 1'b0;
            state_d  = StGap;
            if (rcnt_q < MaxRetry) begin
              rcnt_d = rcnt_q + 1'b1;
            end else begin
              pop    = 1'b1;
              drop_d = 1'b1;
              rcnt_d = '0;
            end
          end
        end
      end
      StGap: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      vcnt_q   <= '0;
      rcnt_q   <= '0;
      dack_q   <= 1'b0;
      dvalid_q <= 1'b0;
      data_q   <= 8'h00;
      done_q   <= 1'b0;
      drop_q   <= 1'b0;
      early_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      vcnt_q   <= vcnt_d;
      rcnt_q   <= rcnt_d;
      dack_q   <= bus.dAck;
      dvalid_q <= dvalid_d;
      data_q   <= data_d;
      done_q   <= done_d;
      drop_q   <= drop_d;
      early_q  <= early_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Storage needs no reset: the pointers define which entries are live
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_q[wr_ptr_q[AW-1:0]] <= bus.in_data;
    end
  end

  a_done_drop_excl: assert property (@(posedge clk) disable iff (reset)
    !(bus.xfer_done && bus.xfer_drop));
  a_vcnt_range: assert property (@(posedge clk) disable iff (reset)
    (state_q == StValid) |-> (vcnt_q >= 3'd1 && vcnt_q <= 3'd4));
  a_valid_matches_state: assert property (@(posedge clk) disable iff (reset)
    (state_q == StValid) |-> bus.dValid);

endmodule

// File: tb/tb_bus_protocol_master.sv
// Self-checking bench for bus_protocol_master: a target model answers each burst from a planned
// dAck pattern, and observed bursts are compared with outcomes derived from the protocol rules.
module tb_bus_protocol_master;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned MAX_RETRY = 2;

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] len;
    logic       done;
    logic       drop;
    logic       early;
    logic       unstable;
  } burst_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic dack_drv = 1'b0;
  int   checks = 0;
  int   errors = 0;

  bus_protocol_master_if bus ();
  assign bus.dAck = dack_drv;

  bus_protocol_master #(
    .DEPTH     (DEPTH),
    .MAX_RETRY (MAX_RETRY)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Target/monitor state
  logic [3:0] plan_q[$];
  burst_t     burst_q[$];
  burst_t     exp_q[$];
  bit         in_burst = 0;
  int         bclk = 0;
  logic [7:0] cur_data = 8'h00;
  logic [3:0] cur_pat = 4'h0;
  bit         cur_early = 0;
  bit         cur_unstable = 0;
  int         n_done = 0, n_drop = 0, n_early = 0;

  // dAck for burst clock k is pattern bit k-1; a burst is recorded on its first low clock
  always @(negedge clk) begin
    burst_t rec;
    if (bus.dValid === 1'b1) begin
      if (!in_burst) begin
        in_burst     = 1;
        bclk         = 1;
        cur_data     = bus.data;
        cur_early    = 0;
        cur_unstable = 0;
        cur_pat      = (plan_q.size() > 0) ? plan_q.pop_front() : 4'h0;
      end else begin
        bclk++;
        if (bus.data !== cur_data) cur_unstable = 1;
      end
      if (bclk == 2) cur_early = bus.ack_early;
      dack_drv = (bclk <= 4) ? cur_pat[bclk-1] : 1'b0;
    end else begin
      if (in_burst) begin
        rec.data     = cur_data;
        rec.len      = 3'(bclk);
        rec.done     = bus.xfer_done;
        rec.drop     = bus.xfer_drop;
        rec.early    = cur_early;
        rec.unstable = cur_unstable;
        burst_q.push_back(rec);
        in_burst = 0;
      end
      dack_drv = 1'b0;
    end
    if (bus.xfer_done === 1'b1) n_done++;
    if (bus.xfer_drop === 1'b1) n_drop++;
    if (bus.ack_early === 1'b1) n_early++;
  end

  function automatic int qual_len(input logic [3:0] p);
    for (int k = 2; k <= 4; k++) begin
      if (p[k-1] && !p[k-2]) return k;
    end
    return 0;
  endfunction

  // Expected bursts for one byte: retry on timeout, drop after MAX_RETRY relaunches
  task automatic model_byte(input logic [7:0] b, input bit rnd, input logic [3:0] fixed);
    burst_t     e;
    int         retries = 0;
    int         k;
    logic [3:0] p;
    forever begin
      p = rnd ? 4'($urandom) : fixed;
      plan_q.push_back(p);
      k          = qual_len(p);
      e.data     = b;
      e.early    = p[0];
      e.unstable = 1'b0;
      e.done     = 1'b0;
      e.drop     = 1'b0;
      if (k != 0) begin
        e.len  = 3'(k);
        e.done = 1'b1;
        exp_q.push_back(e);
        break;
      end
      e.len = 3'd4;
      if (retries < int'(MAX_RETRY)) begin
        retries++;
        exp_q.push_back(e);
      end else begin
        e.drop = 1'b1;
        exp_q.push_back(e);
        break;
      end
    end
  endtask

  task automatic cycle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_test();
    plan_q.delete();
    burst_q.delete();
    exp_q.delete();
    n_done  = 0;
    n_drop  = 0;
    n_early = 0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    int budget = 200;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_accept: in_ready=%b required 1 for byte %02h", bus.in_ready, b);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_bursts(input int n, output bit ok);
    int budget = 3000;
    while (burst_q.size() < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    ok = (burst_q.size() >= n);
    cycle(2);
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    cycle(3);
    @(negedge clk);
    checks++;
    if (bus.dValid !== 1'b0 || bus.data !== 8'h00 || bus.xfer_done !== 1'b0 ||
        bus.xfer_drop !== 1'b0 || bus.ack_early !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: dValid=%b data=%02h done=%b drop=%b early=%b required 0 00 0 0 0",
               bus.dValid, bus.data, bus.xfer_done, bus.xfer_drop, bus.ack_early);
    end
    @(posedge clk);
    #1;
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: in_ready=%b required 1", bus.in_ready);
    end
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (bus.dValid !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_launch: dValid=%b required 0", bus.dValid);
      end
    end
    cycle(1);
  endtask

  task automatic test_single_ack();
    bit ok;
    start_test();
    model_byte(8'hA5, 1'b0, 4'b0010);
    push_byte(8'hA5);
    @(negedge clk);
    checks++;
    if (bus.dValid !== 1'b0) begin
      errors++;
      $display("FAIL latency_low: dValid=%b required 0 one clock after push", bus.dValid);
    end
    @(negedge clk);
    checks++;
    if (bus.dValid !== 1'b1 || bus.data !== 8'hA5) begin
      errors++;
      $display("FAIL latency_high: dValid=%b data=%02h required 1 a5", bus.dValid, bus.data);
    end
    wait_bursts(exp_q.size(), ok);
    checks++;
    if (!ok || burst_q.size() != exp_q.size() || n_done != 1 || n_drop != 0) begin
      errors++;
      $display("FAIL single_count: bursts=%0d done=%0d drop=%0d required 1 1 0",
               burst_q.size(), n_done, n_drop);
    end
    for (int i = 0; i < burst_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (burst_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL single_burst%0d: got %h required %h (data,len,done,drop,early,unstable)",
                 i, burst_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_timeout_drop();
    bit ok;
    start_test();
    model_byte(8'h3C, 1'b0, 4'b0000);
    push_byte(8'h3C);
    wait_bursts(exp_q.size(), ok);
    for (int i = 0; i < burst_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (burst_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL timeout_burst%0d: got %h required %h (data,len,done,drop,early,unstable)",
                 i, burst_q[i], exp_q[i]);
      end
    end
    cycle(12);
    checks++;
    if (!ok || burst_q.size() != 3 || n_drop != 1 || n_done != 0 || bus.dValid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_count: bursts=%0d drop=%0d done=%0d dValid=%b required 3 1 0 0",
               burst_q.size(), n_drop, n_done, bus.dValid);
    end
  endtask

  task automatic test_early_ack();
    bit ok;
    start_test();
    model_byte(8'h11, 1'b0, 4'b0101);
    push_byte(8'h11);
    wait_bursts(exp_q.size(), ok);
    checks++;
    if (!ok || burst_q.size() != 1 || n_early != 1 || n_done != 1) begin
      errors++;
      $display("FAIL early_count: bursts=%0d early=%0d done=%0d required 1 1 1",
               burst_q.size(), n_early, n_done);
    end
    for (int i = 0; i < burst_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (burst_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL early_burst%0d: got %h required %h (data,len,done,drop,early,unstable)",
                 i, burst_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    start_test();
    // First burst acks late so the FIFO fills before anything pops
    model_byte(8'h01, 1'b0, 4'b1000);
    for (int b = 2; b <= 5; b++) model_byte(8'(b), 1'b0, 4'b0010);
    for (int b = 1; b <= 4; b++) push_byte(8'(b));
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_in_ready: in_ready=%b required 0 after 4 pushes", bus.in_ready);
    end
    push_byte(8'h05);
    wait_bursts(exp_q.size(), ok);
    checks++;
    if (!ok || burst_q.size() != exp_q.size() || n_done != 5) begin
      errors++;
      $display("FAIL b2b_count: bursts=%0d done=%0d required %0d 5",
               burst_q.size(), n_done, exp_q.size());
    end
    for (int i = 0; i < burst_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (burst_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_burst%0d: got %h required %h (data,len,done,drop,early,unstable)",
                 i, burst_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    bit         ok;
    logic [7:0] b;
    start_test();
    plan_q.push_back(4'b0000);
    push_byte(8'hF0);
    cycle(3);
    checks++;
    if (bus.dValid !== 1'b1 || bus.data !== 8'hF0) begin
      errors++;
      $display("FAIL midreset_pre: dValid=%b data=%02h required 1 f0", bus.dValid, bus.data);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.dValid !== 1'b0 || bus.data !== 8'h00) begin
      errors++;
      $display("FAIL midreset_post: dValid=%b data=%02h required 0 00", bus.dValid, bus.data);
    end
    cycle(8);
    checks++;
    if (burst_q.size() != 1 || n_done != 0 || n_drop != 0 || bus.dValid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_flush: bursts=%0d done=%0d drop=%0d dValid=%b required 1 0 0 0",
               burst_q.size(), n_done, n_drop, bus.dValid);
    end else begin
      checks++;
      if (burst_q[0].len !== 3'd3 || burst_q[0].done !== 1'b0 || burst_q[0].drop !== 1'b0) begin
        errors++;
        $display("FAIL midreset_burst: len=%0d done=%b drop=%b required 3 0 0",
                 burst_q[0].len, burst_q[0].done, burst_q[0].drop);
      end
    end
    start_test();
    b = 8'($urandom);
    model_byte(b, 1'b0, 4'b0010);
    push_byte(b);
    wait_bursts(exp_q.size(), ok);
    checks++;
    if (!ok || burst_q.size() != 1 || burst_q[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL midreset_relaunch: bursts=%0d first=%h required 1 %h",
               burst_q.size(), (burst_q.size() > 0) ? burst_q[0] : '0, exp_q[0]);
    end
  endtask

  task automatic test_random();
    bit         ok;
    logic [7:0] bytes[$];
    int         exp_done = 0, exp_drop = 0, exp_early = 0;
    start_test();
    for (int i = 0; i < 20; i++) begin
      bytes.push_back(8'($urandom));
      model_byte(bytes[i], 1'b1, 4'h0);
    end
    foreach (exp_q[i]) begin
      exp_done  += int'(exp_q[i].done);
      exp_drop  += int'(exp_q[i].drop);
      exp_early += int'(exp_q[i].early);
    end
    foreach (bytes[i]) begin
      push_byte(bytes[i]);
      cycle($urandom_range(0, 3));
    end
    wait_bursts(exp_q.size(), ok);
    checks++;
    if (!ok || burst_q.size() != exp_q.size() || n_done != exp_done || n_drop != exp_drop ||
        n_early != exp_early) begin
      errors++;
      $display("FAIL random_count: bursts=%0d done=%0d drop=%0d early=%0d required %0d %0d %0d %0d",
               burst_q.size(), n_done, n_drop, n_early, exp_q.size(), exp_done, exp_drop,
               exp_early);
    end
    for (int i = 0; i < burst_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (burst_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL random_burst%0d: got %h required %h (data,len,done,drop,early,unstable)",
                 i, burst_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    test_reset();
    test_single_ack();
    test_timeout_drop();
    test_early_ack();
    test_back_to_back();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
